// File: rtl/commit_trace_pkg.sv
// Shared types and default widths for the commit trace buffer.
//   trace_entry_t  : one buffered commit as presented on the trace port
//   retire_slot_t  : one retire-port record after unpacking the flat buses
// Module parameters PDST_W / CNT_W may be narrower than, but never wider
// than, the TRACE_* widths used by the packed entry type.
package commit_trace_pkg;

   localparam int TRACE_PDST_W    = 6;
   localparam int TRACE_CNT_W     = 64;
   localparam int TRACE_DEPTH_DEF = 16;
   localparam int HANG_LIMIT_DEF  = 2000;

   typedef struct packed {
      logic [31:0]             pc;
      logic [TRACE_PDST_W-1:0] pdst;
      logic                    wr;
      logic [31:0]             data;
      logic [TRACE_CNT_W-1:0]  seq;
   } trace_entry_t;

   typedef struct packed {
      logic                    valid;
      logic                    flushed;
      logic                    wr;
      logic [TRACE_PDST_W-1:0] pdst;
      logic [31:0]             pc;
      logic [31:0]             data;
   } retire_slot_t;

   function automatic logic slot_accepted(input retire_slot_t s);
      return s.valid & ~s.flushed;
   endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Two-push / one-pop FIFO of trace entries.
//   push_vld[1:0]   : ordered push requests (slot 1 only with slot 0)
//   push_entry0/1   : entries for slot 0 / slot 1
//   push_acc[1:0]   : which requests were stored this cycle
//   pop             : remove head (ignored when empty)
//   head            : head entry, all-zero while empty
//   count           : occupancy, one bit wider than the pointers
//   clear           : synchronous empty, overrides push/pop
module commit_trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = TRACE_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [1:0]               push_vld,
   input  trace_entry_t             push_entry0,
   input  trace_entry_t             push_entry1,
   output logic [1:0]               push_acc,
   input  logic                     pop,
   output trace_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   trace_entry_t  mem_q [DEPTH];
   trace_entry_t  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   free;
   logic [AW-1:0] wr_ptr_nx;
   logic          pop_fire;

   always_comb begin
      // Space is judged on start-of-cycle occupancy; a same-cycle pop
      // does not make room for a push.
      free        = (AW+1)'(DEPTH) - count_q;
      push_acc[0] = ~clear & push_vld[0] & (free != '0);
      push_acc[1] = ~clear & push_vld[0] & push_vld[1] & (free >= (AW+1)'(2));
      pop_fire    = ~clear & pop & (count_q != '0);
      wr_ptr_nx   = wr_ptr_q + AW'(1);

      mem_d = mem_q;
      if (push_acc[0]) mem_d[wr_ptr_q]  = push_entry0;
      if (push_acc[1]) mem_d[wr_ptr_nx] = push_entry1;

      wr_ptr_d = wr_ptr_q + AW'(push_acc[0]) + AW'(push_acc[1]);
      rd_ptr_d = rd_ptr_q + AW'(pop_fire);
      count_d  = count_q + (AW+1)'(push_acc[0]) + (AW+1)'(push_acc[1])
                 - (AW+1)'(pop_fire);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset: an empty FIFO masks it at the head output.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace stage behind the dual retire ports.
//   ret_*          : per-slot retire records (slot 0 in the low lane)
//   current_pc     : fetch PC sampled by the hang watchdog
//   trace_*        : valid/ready drain port, one commit per cycle
//   commit_count   : commits accepted since reset/clear (also next seq)
//   drop_count     : commits lost to overflow, saturating; overflow sticky
//   hang_detected  : sticky, PC unchanged for HANG_LIMIT cycles
//   clear          : synchronous wipe of FIFO, counters and flags
module commit_trace_buffer
   import commit_trace_pkg::*;
#(
   parameter int DEPTH      = TRACE_DEPTH_DEF,
   parameter int PDST_W     = TRACE_PDST_W,
   parameter int CNT_W      = TRACE_CNT_W,
   parameter int HANG_LIMIT = HANG_LIMIT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic [1:0]          ret_valid,
   input  logic [1:0]          ret_flushed,
   input  logic [1:0]          ret_valid_write,
   input  logic [2*PDST_W-1:0] ret_pdst,
   input  logic [63:0]         ret_pc,
   input  logic [63:0]         ret_data,
   input  logic [31:0]         current_pc,
   output logic                trace_valid,
   input  logic                trace_ready,
   output logic [31:0]         trace_pc,
   output logic [PDST_W-1:0]   trace_pdst,
   output logic                trace_wr,
   output logic [31:0]         trace_data,
   output logic [CNT_W-1:0]    trace_seq,
   output logic [CNT_W-1:0]    commit_count,
   output logic [31:0]         drop_count,
   output logic                overflow,
   output logic                hang_detected
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(HANG_LIMIT + 1);

   retire_slot_t slot [2];
   trace_entry_t ent0, ent1, head;
   logic         acc0, acc1;
   logic [1:0]   push_vld, push_acc;
   logic [AW:0]  fifo_count;

   logic [CNT_W-1:0] commit_count_q, commit_count_d;
   logic [31:0]      drop_count_q, drop_count_d;
   logic             overflow_q, overflow_d;
   logic [31:0]      old_pc_q, old_pc_d;
   logic [HW-1:0]    hang_cnt_q, hang_cnt_d;
   logic             hang_q, hang_d;
   logic [1:0]       n_acc, n_drop;
   logic [32:0]      drop_sum;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         slot[i].valid   = ret_valid[i];
         slot[i].flushed = ret_flushed[i];
         slot[i].wr      = ret_valid_write[i];
         slot[i].pdst    = TRACE_PDST_W'(ret_pdst[i*PDST_W +: PDST_W]);
         slot[i].pc      = ret_pc[i*32 +: 32];
         slot[i].data    = ret_data[i*32 +: 32];
      end
      // In-order retire: slot 1 only counts behind an accepted slot 0.
      acc0 = slot_accepted(slot[0]);
      acc1 = acc0 & slot_accepted(slot[1]);

      ent0.pc   = slot[0].pc;
      ent0.pdst = slot[0].pdst;
      ent0.wr   = slot[0].wr;
      ent0.data = slot[0].data;
      ent0.seq  = TRACE_CNT_W'(commit_count_q);
      ent1.pc   = slot[1].pc;
      ent1.pdst = slot[1].pdst;
      ent1.wr   = slot[1].wr;
      ent1.data = slot[1].data;
      ent1.seq  = TRACE_CNT_W'(commit_count_q + CNT_W'(1));

      push_vld = clear ? 2'b00 : {acc1, acc0};
   end

   commit_trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .push_vld    (push_vld),
      .push_entry0 (ent0),
      .push_entry1 (ent1),
      .push_acc    (push_acc),
      .pop         (trace_ready),
      .head        (head),
      .count       (fifo_count)
   );

   always_comb begin
      // Dropped commits still consume a sequence number.
      n_acc    = {1'b0, push_vld[0]} + {1'b0, push_vld[1]};
      n_drop   = {1'b0, push_vld[0] & ~push_acc[0]}
               + {1'b0, push_vld[1] & ~push_acc[1]};
      drop_sum = {1'b0, drop_count_q} + 33'(n_drop);

      commit_count_d = commit_count_q + CNT_W'(n_acc);
      drop_count_d   = drop_sum[32] ? '1 : drop_sum[31:0];
      overflow_d     = overflow_q | (n_drop != 2'd0);

      old_pc_d   = old_pc_q;
      hang_cnt_d = hang_cnt_q;
      if (current_pc == old_pc_q) begin
         if (hang_cnt_q != HW'(HANG_LIMIT)) hang_cnt_d = hang_cnt_q + HW'(1);
      end else begin
         hang_cnt_d = '0;
         old_pc_d   = current_pc;
      end
      hang_d = hang_q | (hang_cnt_d == HW'(HANG_LIMIT));

      if (clear) begin
         commit_count_d = '0;
         drop_count_d   = '0;
         overflow_d     = 1'b0;
         old_pc_d       = '0;
         hang_cnt_d     = '0;
         hang_d         = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_count_q <= '0;
         drop_count_q   <= '0;
         overflow_q     <= 1'b0;
         old_pc_q       <= '0;
         hang_cnt_q     <= '0;
         hang_q         <= 1'b0;
      end else begin
         commit_count_q <= commit_count_d;
         drop_count_q   <= drop_count_d;
         overflow_q     <= overflow_d;
         old_pc_q       <= old_pc_d;
         hang_cnt_q     <= hang_cnt_d;
         hang_q         <= hang_d;
      end
   end

   assign trace_valid   = (fifo_count != '0);
   assign trace_pc      = head.pc;
   assign trace_pdst    = head.pdst[PDST_W-1:0];
   assign trace_wr      = head.wr;
   assign trace_data    = head.data;
   assign trace_seq     = head.seq[CNT_W-1:0];
   assign commit_count  = commit_count_q;
   assign drop_count    = drop_count_q;
   assign overflow      = overflow_q;
   assign hang_detected = hang_q;

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable retirement-trace stage directly downstream of the core's dual retire ports (slot 0 and slot 1 writeback-to-ARF records). Filters flushed retirements, tags each commit with a sequence number, buffers up to two commits per cycle in a 2-write/1-read FIFO, and drains one entry per cycle over a valid/ready trace port. Also keeps commit/drop statistics and a PC-hang watchdog that flags end-of-program or deadlock.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥4.
- PDST_W, 6: physical destination register index width.
- CNT_W, 64: commit_count and sequence number width.
- HANG_LIMIT, 2000: consecutive unchanged-PC cycles that raise hang_detected.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear of FIFO, counters, sticky flags.
- ret_valid  in  2  per-slot valid_commit.
- ret_flushed  in  2  per-slot flushed marker.
- ret_valid_write  in  2  per-slot register-write flag.
- ret_pdst  in  2×PDST_W  per-slot physical destination.
- ret_pc  in  2×32  per-slot PC.
- ret_data  in  2×32  per-slot result data.
- current_pc  in  32  fetch PC sampled by watchdog.
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  sink accepts head.
- trace_pc / trace_pdst / trace_wr / trace_data  out  32 / PDST_W / 1 / 32  head fields.
- trace_seq  out  CNT_W  head sequence number.
- commit_count  out  CNT_W  accepted commits since reset/clear.
- drop_count  out  32  commits lost to FIFO overflow, saturating.
- overflow  out  1  sticky, set on any drop.
- hang_detected  out  1  sticky watchdog flag.

## Operation
- Slot accepted iff ret_valid[i] & ~ret_flushed[i]. Slot 1 is accepted only if slot 0 is accepted the same cycle (in-order retire); otherwise ignored and not counted.
- Accepted commits get seq = commit_count (slot 0), commit_count+1 (slot 1); commit_count += number accepted (0/1/2).
- Enqueue order: slot 0 then slot 1. Free space = DEPTH − occupancy at cycle start; a same-cycle pop does not create space. Commits beyond free space are dropped (slot 1 first), still consume a seq number, drop_count += dropped, overflow set.
- Pop on trace_valid & trace_ready; trace_valid = occupancy ≠ 0. Head fields stable while trace_valid & ~trace_ready.
- Watchdog: registers old_pc, hang_cnt. current_pc == old_pc → hang_cnt increments, saturating at HANG_LIMIT; else hang_cnt ← 0, old_pc ← current_pc. hang_detected set when hang_cnt becomes HANG_LIMIT; stays set until reset/clear even if PC moves.
- clear has priority over all activity: FIFO emptied, commit_count/drop_count/hang_cnt/old_pc ← 0, flags ← 0; retire inputs that cycle discarded.

## Timing
- Reset values: trace_valid 0, all trace fields 0, commit_count 0, drop_count 0, overflow 0, hang_detected 0, old_pc 0, hang_cnt 0, FIFO empty.
- Enqueue at edge N → trace_valid high after edge N (1-cycle latency); empty FIFO with 2 commits: slot 0 presented first, slot 1 next pop.
- Simultaneous 2 pushes + 1 pop with occupancy DEPTH−1: one push accepted, one dropped; occupancy ends DEPTH−1.
- Pointer wrap-around modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits to distinguish full/empty.
- current_pc held at 0 from reset release: hang_detected rises after the HANG_LIMIT-th rising edge.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial entries survive.

## Structure
- commit_trace_pkg: trace_entry_t {pc[31:0], pdst[PDST_W-1:0], wr, data[31:0], seq[CNT_W-1:0]}, retire slot struct, default width constants.
- Sub-module commit_trace_fifo: 2-push/1-pop FIFO of trace_entry_t with count, ordered push, space-limited accept output. Watchdog and counters stay in the top.

## Test plan
- Single commit pc=0x100, pdst=5, data=0xDEAD, trace_ready=1 → next cycle trace_valid=1, trace_seq=0, commit_count=1.
- Dual commit pc=0x200/0x204, trace_ready=0 → two entries, seq 0 then 1; raising ready drains 0x200 then 0x204.
- Slot 0 flushed, slot 1 valid → nothing enqueued, commit_count unchanged; slot 1 flushed only → one entry.
- trace_ready=0, 9 dual-commit cycles into DEPTH=16 → 16 entries stored, drop_count=2, overflow=1, seqs 0–15 drained, next accepted seq 18.
- current_pc constant 0x80 with HANG_LIMIT=2000 → hang_detected rises 2001 edges after first 0x80 sample; PC change afterwards keeps it 1; clear drops it.
- Async reset asserted with 5 entries buffered → trace_valid=0, all counters 0 immediately; next commit gets seq 0.
